load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/load_store_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 width codes, exception codes, LSU state encoding.
// Pure definitions, no latency or flow control.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   // Unsigned widths are load-only; stores have no use for the sign bit.
   function automatic logic width_legal(input logic we, input logic [2:0] f3);
      case (f3)
         F3_B, F3_H, F3_W: width_legal = 1'b1;
         F3_BU, F3_HU:     width_legal = ~we;
         default:          width_legal = 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         F3_H, F3_HU: misaligned = lo[0];
         F3_W:        misaligned = (lo != 2'b00);
         default:     misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated write data, load lane select and extension.
// Purely combinational, zero latency, no flow control.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   output logic [31:0] load_data
);

   logic [31:0] shifted;
   logic        sext;

   assign shifted = mem_rdata >> {byte_off, 3'b000};
   assign sext    = ~funct3[2];

   always_comb begin
      mem_be    = 4'b1111;
      mem_wdata = wdata;
      load_data = mem_rdata;
      case (funct3)
         F3_B, F3_BU: begin
            mem_be    = 4'b0001 << byte_off;
            mem_wdata = {4{wdata[7:0]}};
            load_data = {{24{shifted[7] & sext}}, shifted[7:0]};
         end
         F3_H, F3_HU: begin
            mem_be    = 4'b0011 << {byte_off[1], 1'b0};
            mem_wdata = {2{wdata[15:0]}};
            load_data = {{16{shifted[15] & sext}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, done two cycles after request at best.
// Stalls the core from request until the DONE cycle; waits on mem_ready up to TIMEOUT_CYCLES.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic [1:0]  exc,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e    state_q;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [CW-1:0] cnt_q;
   logic          done_q;
   logic [1:0]    exc_q;
   logic [31:0]   rdata_q;

   logic [3:0]    be;
   logic [31:0]   st_data;
   logic [31:0]   ld_data;

   lsu_align u_align (
      .funct3    (f3_q),
      .byte_off  (addr_q[1:0]),
      .wdata     (wdata_q),
      .mem_rdata (mem_rdata),
      .mem_be    (be),
      .mem_wdata (st_data),
      .load_data (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         exc_q   <= EXC_NONE;
         rdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= funct3;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  cnt_q   <= '0;
                  rdata_q <= '0;
                  if (!width_legal(req_we, funct3)) begin
                     exc_q   <= EXC_ILLEGAL;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else if (misaligned(funct3, addr[1:0])) begin
                     exc_q   <= EXC_MISALIGN;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     exc_q   <= EXC_NONE;
                     state_q <= ST_BUSY;
                  end
               end
            end
            // mem_ready is tested first so it beats a timeout landing in the same cycle.
            ST_BUSY: begin
               if (mem_ready) begin
                  rdata_q <= we_q ? 32'd0 : ld_data;
                  exc_q   <= EXC_NONE;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  rdata_q <= '0;
                  exc_q   <= EXC_TIMEOUT;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign stall     = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_BUSY);
   assign done      = done_q;
   assign exc       = exc_q;
   assign rdata     = rdata_q;
   assign mem_req   = (state_q == ST_BUSY);
   assign mem_we    = mem_req & we_q;
   assign mem_be    = mem_req ? be : 4'b0000;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = st_data;

endmodule
